logic_op_sequencer: RTL

//  Command-side driver for the 16-bit logic unit: accepts one job (A, B, start opcode, op count) over a

---
 rtl/logic_op_pkg.sv | 21 ++
 rtl/logic_op_out_stage.sv | 44 ++++
 rtl/logic_op_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/logic_op_pkg.sv
// Shared types and constants for the logic-unit opcode sequencer.
// The opcode-advance rule lives here so it is defined in exactly one place.
package logic_op_pkg;

  localparam int OPW = 4;
  localparam logic [OPW-1:0] LOGIC_BASE = 4'b1000;
  localparam logic [OPW-1:0] OP_MAX     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Sweeps wrap back into the logic range rather than into arithmetic opcodes.
  function automatic logic [OPW-1:0] next_opcode(input logic [OPW-1:0] op);
    return (op == OP_MAX) ? LOGIC_BASE : op + OPW'(1);
  endfunction

endpackage

// File: rtl/logic_op_out_stage.sv
// Single-entry result register with valid/ready handshake.
// A load in the same cycle as a handshake replaces the beat without a bubble.
module logic_op_out_stage
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] new_data,
  input  logic [OPW-1:0]   new_opcode,
  input  logic             new_err,
  input  logic             new_last,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [OPW-1:0]   opcode,
  output logic             err,
  output logic             last,
  output logic             cap
);

  assign cap = !valid || ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      data   <= '0;
      opcode <= '0;
      err    <= 1'b0;
      last   <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      data   <= new_data;
      opcode <= new_opcode;
      err    <= new_err;
      last   <= new_last;
    end else if (ready) begin
      valid  <= 1'b0;
    end
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Issues a run of consecutive logic opcodes to the combinational logic unit
// and streams the registered results back under valid/ready backpressure.
//
// state | meaning
// IDLE  | waiting for a job, cmd_ready=1
// ISSUE | lu_* driven; one result captured per cycle when the out stage has room
// DRAIN | last beat captured, waiting for its handshake
// DONE  | one-cycle done pulse
module logic_op_sequencer
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_op_start,
  input  logic [CNTW-1:0]  cmd_count,
  output logic [OPW-1:0]   lu_opcode,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  input  logic [WIDTH-1:0] lu_result,
  input  logic             lu_sel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [OPW-1:0]   res_opcode,
  output logic             res_err,
  output logic             res_last,
  output logic             busy,
  output logic             done
);

  state_t          state, state_nxt;
  logic [CNTW-1:0] remaining;
  logic            cap;
  logic            load;
  logic            accept;
  logic            last_op;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign accept    = cmd_valid && (state == IDLE);
  assign last_op   = (remaining == '0);

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = ISSUE;
      ISSUE: begin
        if (cap) begin
          load = 1'b1;
          if (last_op) state_nxt = DRAIN;
        end
      end
      DRAIN: if (res_valid && res_ready) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      lu_opcode <= '0;
      lu_a      <= '0;
      lu_b      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lu_a      <= cmd_a;
        lu_b      <= cmd_b;
        lu_opcode <= cmd_op_start;
        remaining <= cmd_count;
      end else if (load && !last_op) begin
        remaining <= remaining - CNTW'(1);
        lu_opcode <= next_opcode(lu_opcode);
      end
    end
  end

  // Error flag records that the unit did not claim the opcode (start below LOGIC_BASE).
  logic_op_out_stage #(.WIDTH(WIDTH)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .new_data   (lu_result),
    .new_opcode (lu_opcode),
    .new_err    (!lu_sel),
    .new_last   (last_op),
    .ready      (res_ready),
    .valid      (res_valid),
    .data       (res_data),
    .opcode     (res_opcode),
    .err        (res_err),
    .last       (res_last),
    .cap        (cap)
  );

endmodule
